// File: rtl/arb_pkg.sv
// Shared types for the 4:1 round-robin arbiter: channel index, arbiter state and
// the rotating-priority index helper.
package arb_pkg;

  localparam int N_CH = 4;

  typedef logic [1:0] ch_idx_t;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // Channel reached by stepping k positions past base, wrapping modulo N_CH.
  function automatic ch_idx_t rot_idx(input ch_idx_t base, input int unsigned k);
    ch_idx_t step;
    step = ch_idx_t'(k);
    return base + step;
  endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Rotating-priority search: the first requester after last_grant, with
// wrap-around, wins.
module rr_pick_4
  import arb_pkg::*;
(
  input  logic [N_CH-1:0] req,
  input  ch_idx_t         last_grant,
  output ch_idx_t         gnt_idx,
  output logic            any_req
);

  ch_idx_t w_idx;
  logic    w_found;

  always_comb begin
    gnt_idx = rot_idx(last_grant, 1);
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= N_CH; k++) begin
      w_idx = rot_idx(last_grant, k);
      if (!w_found && req[w_idx]) begin
        gnt_idx = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/rr_arb_4_1.sv
// Four-source round-robin arbiter with packet-level locking and a single-entry
// registered output stage that can reload in the same cycle it drains.
module rr_arb_4_1
  import arb_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  in_valid,
  input  logic [N_CH-1:0]  in_last,
  input  logic [WIDTH-1:0] in_data [0:N_CH-1],
  output logic [N_CH-1:0]  in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [1:0]       out_sel,
  input  logic             out_ready
);

  arb_state_t       r_state_p0;
  arb_state_t       w_state_nxt;
  ch_idx_t          r_last_grant;
  ch_idx_t          r_cur;
  ch_idx_t          w_pick;
  ch_idx_t          w_gnt;
  logic             w_any_req;
  logic             w_load;
  logic             w_xfer;
  logic [N_CH-1:0]  w_ready;

  logic             r_vld_p1;
  logic [WIDTH-1:0] r_data_p1;
  logic             r_last_p1;
  ch_idx_t          r_sel_p1;

  rr_pick_4 u_pick (
    .req        (in_valid),
    .last_grant (r_last_grant),
    .gnt_idx    (w_pick),
    .any_req    (w_any_req)
  );

  assign w_load = ~r_vld_p1 | out_ready;
  assign w_gnt  = (r_state_p0 == LOCK) ? r_cur : w_pick;
  assign w_xfer = |(in_valid & w_ready);

  // Stage p0: arbitration state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_p0 <= ARB;
    end else begin
      r_state_p0 <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state_p0;
    case (r_state_p0)
      ARB:  if (w_xfer && !in_last[w_gnt]) w_state_nxt = LOCK;
      LOCK: if (w_xfer &&  in_last[w_gnt]) w_state_nxt = ARB;
      default: w_state_nxt = ARB;
    endcase
  end

  // in_ready depends only on valid, output occupancy and state, never on data
  always_comb begin
    w_ready = '0;
    if (w_load) begin
      if (r_state_p0 == LOCK) begin
        w_ready[r_cur] = 1'b1;
      end else if (w_any_req) begin
        w_ready[w_pick] = 1'b1;
      end
    end
  end

  assign in_ready = w_ready;

  // Priority only rotates at packet end, so single-beat packets rotate every beat
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= ch_idx_t'(N_CH - 1);
      r_cur        <= '0;
    end else if (w_xfer) begin
      if (in_last[w_gnt]) begin
        r_last_grant <= w_gnt;
      end else if (r_state_p0 == ARB) begin
        r_cur <= w_pick;
      end
    end
  end

  // Stage p1: output register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
      r_last_p1 <= 1'b0;
      r_sel_p1  <= '0;
    end else if (w_load) begin
      r_vld_p1 <= w_xfer;
      if (w_xfer) begin
        r_data_p1 <= in_data[w_gnt];
        r_last_p1 <= in_last[w_gnt];
        r_sel_p1  <= w_gnt;
      end
    end
  end

  assign out_valid = r_vld_p1;
  assign out_data  = r_data_p1;
  assign out_last  = r_last_p1;
  assign out_sel   = r_sel_p1;

endmodule

// File: tb/tb_rr_arb_4_1.sv
// Bench for rr_arb_4_1: directed scenarios followed by random traffic, all
// compared against a cycle-level behavioural model of the arbitration rules.
module tb_rr_arb_4_1;

  logic       clk;
  logic       rst;
  logic [3:0] in_valid;
  logic [3:0] in_last;
  logic [3:0] in_data [0:3];
  logic [3:0] in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_last;
  logic [1:0] out_sel;
  logic       out_ready;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int       m_lg;
  bit       m_lock;
  int       m_own;
  bit       m_ovld;
  bit [3:0] m_odata;
  bit       m_olast;
  int       m_osel;

  logic [3:0] rdy_pre;

  rr_arb_4_1 #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_rdy();
    logic [3:0] r;
    int c;
    r = 4'b0000;
    if (m_ovld && !out_ready) return r;
    if (m_lock) begin
      r[m_own] = 1'b1;
      return r;
    end
    for (int k = 1; k <= 4; k++) begin
      c = (m_lg + k) % 4;
      if (in_valid[c]) begin
        r[c] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    m_lg    = 3;
    m_lock  = 1'b0;
    m_own   = 0;
    m_ovld  = 1'b0;
    m_odata = 4'h0;
    m_olast = 1'b0;
    m_osel  = 0;
  endtask

  task automatic model_update();
    logic [3:0] r;
    logic x;
    int g;
    if (rst) begin
      model_reset();
      return;
    end
    r = model_rdy();
    x = |(r & in_valid);
    g = 0;
    for (int i = 0; i < 4; i++) if (r[i]) g = i;
    if (!m_ovld || out_ready) begin
      m_ovld = x;
      if (x) begin
        m_odata = in_data[g];
        m_olast = in_last[g];
        m_osel  = g;
      end
    end
    if (x) begin
      if (in_last[g]) begin
        m_lg   = g;
        m_lock = 1'b0;
      end else begin
        m_lock = 1'b1;
        m_own  = g;
      end
    end
  endtask

  // One clock: check in_ready before the edge, advance model, check outputs after
  task automatic step();
    #1;
    rdy_pre = in_ready;
    if (!rst) chk("in_ready", 32'(in_ready), 32'(model_rdy()));
    @(posedge clk);
    model_update();
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_ovld));
    if (m_ovld) begin
      chk("out_data", 32'(out_data), 32'(m_odata));
      chk("out_last", 32'(out_last), 32'(m_olast));
      chk("out_sel", 32'(out_sel), 32'(m_osel));
    end
  endtask

  task automatic set_all(input logic [3:0] v, input logic [3:0] l);
    in_valid = v;
    in_last  = l;
  endtask

  initial begin
    logic [1:0] sel_seq [0:4];
    logic [3:0] d0;
    logic [1:0] s0;

    rst = 1'b1;
    out_ready = 1'b0;
    set_all(4'b0000, 4'b0000);
    for (int i = 0; i < 4; i++) in_data[i] = 4'(i + 8);
    model_reset();

    // reset state
    step();
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_out_sel", 32'(out_sel), 0);

    // reset priority: sel sequence 0,1,2,3,0
    set_all(4'b1111, 4'b1111);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      sel_seq[i] = out_sel;
    end
    chk("prio_sel0", 32'(sel_seq[0]), 0);
    chk("prio_sel1", 32'(sel_seq[1]), 1);
    chk("prio_sel2", 32'(sel_seq[2]), 2);
    chk("prio_sel3", 32'(sel_seq[3]), 3);
    chk("prio_sel4", 32'(sel_seq[4]), 0);

    // packet lock: source 2 sends A,B,C while source 0 stays valid
    set_all(4'b0101, 4'b0001);
    in_data[0] = 4'h1;
    in_data[2] = 4'hA;
    step();
    chk("lock_selA", 32'(out_sel), 2);
    chk("lock_dataA", 32'(out_data), 32'hA);
    in_data[2] = 4'hB;
    step();
    chk("lock_r0_B", 32'(rdy_pre[0]), 0);
    chk("lock_dataB", 32'(out_data), 32'hB);
    in_data[2] = 4'hC;
    in_last[2] = 1'b1;
    step();
    chk("lock_r0_C", 32'(rdy_pre[0]), 0);
    chk("lock_dataC", 32'(out_data), 32'hC);
    chk("lock_selC", 32'(out_sel), 2);
    set_all(4'b0001, 4'b0001);
    step();
    chk("lock_after_sel", 32'(out_sel), 0);

    // backpressure: hold for three cycles, then reload with no bubble
    set_all(4'b1111, 4'b1111);
    step();
    d0 = out_data;
    s0 = out_sel;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_rdy", 32'(rdy_pre), 0);
      chk("bp_data", 32'(out_data), 32'(d0));
      chk("bp_sel", 32'(out_sel), 32'(s0));
    end
    out_ready = 1'b1;
    step();
    chk("bp_reload_rdy", 32'(rdy_pre != 4'b0000), 1);
    chk("bp_reload_vld", 32'(out_valid), 1);
    chk("bp_reload_sel", 32'(out_sel), 32'((s0 + 1) % 4));

    // wrap-around from last_grant=3
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_all(4'b0010, 4'b1111);
    step();
    chk("wrap_sel1", 32'(out_sel), 1);
    set_all(4'b1011, 4'b1111);
    step();
    chk("wrap_sel3", 32'(out_sel), 3);
    step();
    chk("wrap_sel0", 32'(out_sel), 0);

    // reset in the middle of a packet
    set_all(4'b0100, 4'b0000);
    step();
    chk("mid_vld", 32'(out_valid), 1);
    rst = 1'b1;
    step();
    chk("mid_rst_vld", 32'(out_valid), 0);
    rst = 1'b0;
    set_all(4'b1111, 4'b1111);
    step();
    chk("mid_after_sel", 32'(out_sel), 0);

    // idle cycles inside a packet from source 1
    set_all(4'b0010, 4'b0000);
    step();
    chk("idle_sel1", 32'(out_sel), 1);
    set_all(4'b1000, 4'b1000);
    step();
    chk("idle_r3_a", 32'(rdy_pre[3]), 0);
    step();
    chk("idle_r3_b", 32'(rdy_pre[3]), 0);
    set_all(4'b1010, 4'b1010);
    step();
    chk("idle_r3_c", 32'(rdy_pre[3]), 0);
    chk("idle_end_sel", 32'(out_sel), 1);
    set_all(4'b1000, 4'b1000);
    step();
    chk("idle_r3_free", 32'(rdy_pre[3]), 1);

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 59) == 0);
      in_valid  = 4'($urandom);
      in_last   = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) in_data[i] = 4'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
